// File: rtl/exec_unit_seq.sv
// exec_unit_seq -- single-issue execution unit with a one-cycle ALU path and
// an iterative shift-add multiplier.
//
// Ports:
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   flush           abort the in-flight multiply / drop the presented operation
//   in_valid        operation fields valid this cycle
//   in_ready        unit can accept an operation (== !busy)
//   ext_op          immediate extension: 1 sign-extend, 0 zero-extend
//   alu_src         operand B select: 0 bus_b, 1 extended imm
//   alu_ctr         ALU operation code
//   mul_op          1 selects the multiply (alu_ctr ignored)
//   bus_a, bus_b    operands (WIDTH bits)
//   imm             immediate (IMM_W bits)
//   out_valid       one-cycle pulse marking a new result
//   result          registered result
//   zero            registered, high when result is all zeros
//   overflow        registered signed overflow
//   busy            multiply in progress
module exec_unit_seq #(
    parameter int WIDTH = 32,
    parameter int IMM_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             ext_op,
    input  logic             alu_src,
    input  logic [2:0]       alu_ctr,
    input  logic             mul_op,
    input  logic [WIDTH-1:0] bus_a,
    input  logic [WIDTH-1:0] bus_b,
    input  logic [IMM_W-1:0] imm,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic {
        ST_IDLE,
        ST_MUL
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               overflow_q, overflow_d;
    logic               out_valid_q, out_valid_d;

    logic [WIDTH-1:0]   imm_ext;
    logic [WIDTH-1:0]   op_b;
    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   diff;
    logic               add_of;
    logic               sub_of;
    logic               slt;
    logic               sltu;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_of;
    logic [WIDTH-1:0]   acc_step;
    logic               accept;

    // Operand formation and the combinational ALU.
    always_comb begin
        imm_ext = {{(WIDTH-IMM_W){ext_op & imm[IMM_W-1]}}, imm};
        op_b    = alu_src ? imm_ext : bus_b;
        sum     = bus_a + op_b;
        diff    = bus_a - op_b;
        // Signed overflow: operands of equal sign (add) or opposite sign (sub)
        // producing a result whose sign differs from operand A.
        add_of  = (bus_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1]  != bus_a[WIDTH-1]);
        sub_of  = (bus_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != bus_a[WIDTH-1]);
        slt     = $signed(bus_a) < $signed(op_b);
        sltu    = bus_a < op_b;

        alu_res = '0;
        alu_of  = 1'b0;
        case (alu_ctr)
            3'b000: alu_res = sum;
            3'b001: alu_res = diff;
            3'b010: begin
                alu_res = sum;
                alu_of  = add_of;
            end
            3'b011: begin
                alu_res = diff;
                alu_of  = sub_of;
            end
            3'b100: alu_res = bus_a & op_b;
            3'b101: alu_res = bus_a | op_b;
            3'b110: alu_res = {{(WIDTH-1){1'b0}}, slt};
            default: alu_res = {{(WIDTH-1){1'b0}}, sltu};
        endcase
    end

    // Shift-add: the multiplicand moves left and the multiplier right, so the
    // current multiplier LSB decides whether the aligned multiplicand is added.
    always_comb begin
        acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    end

    // Flush takes priority over acceptance.
    always_comb begin
        accept = in_valid && (state_q == ST_IDLE) && !flush;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        result_d    = result_q;
        zero_d      = zero_q;
        overflow_d  = overflow_q;
        out_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (mul_op) begin
                        state_d  = ST_MUL;
                        cnt_d    = '0;
                        mcand_d  = bus_a;
                        mplier_d = op_b;
                        acc_d    = '0;
                    end else begin
                        result_d    = alu_res;
                        zero_d      = (alu_res == '0);
                        overflow_d  = alu_of;
                        out_valid_d = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH-1)) begin
                    state_d     = ST_IDLE;
                    result_d    = acc_step;
                    zero_d      = (acc_step == '0);
                    overflow_d  = 1'b0;
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Flush kills the multiply and any pending result; visible outputs hold.
        if (flush) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            result_d    = result_q;
            zero_d      = zero_q;
            overflow_d  = overflow_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            zero_q      <= 1'b1;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign busy      = (state_q == ST_MUL);
    assign in_ready  = !busy;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign overflow  = overflow_q;

endmodule

// File: doc/exec_unit_seq.md
EXEC_UNIT_SEQ -- requirements
Module: exec_unit_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32: datapath width of operands and result (legal values 8 to 64).
REQ-002 SHALL have parameter IMM_W, default 16: immediate width, which is less than WIDTH.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port flush, input, 1 bit: abort the in-flight operation and kill the pending result.
REQ-006 SHALL have port in_valid, input, 1 bit: the operation fields are valid this cycle.
REQ-007 SHALL have port in_ready, output, 1 bit: the unit can accept an operation; equals !busy.
REQ-008 SHALL have port ext_op, input, 1 bit: immediate extension; 1 means sign-extend, 0 means zero-extend.
REQ-009 SHALL have port alu_src, input, 1 bit: operand B select; 0 selects bus_b, 1 selects the extended imm.
REQ-010 SHALL have port alu_ctr, input, 3 bits: ALU operation code per REQ-021.
REQ-011 SHALL have port mul_op, input, 1 bit: 1 selects the iterative multiply and ignores alu_ctr.
REQ-012 SHALL have port bus_a, input, WIDTH bits: operand A.
REQ-013 SHALL have port bus_b, input, WIDTH bits: register operand B.
REQ-014 SHALL have port imm, input, IMM_W bits: the immediate.
REQ-015 SHALL have port out_valid, output, 1 bit: one-cycle pulse marking a new result.
REQ-016 SHALL have port result, output, WIDTH bits: registered result.
REQ-017 SHALL have port zero, output, 1 bit: registered; high when the result is all zeros.
REQ-018 SHALL have port overflow, output, 1 bit: registered signed overflow of the operation.
REQ-019 SHALL have port busy, output, 1 bit: a multiply is in progress.

Function
REQ-020 SHALL accept an operation on a rising edge where in_valid and in_ready are both high; operand B is bus_b when alu_src=0 and the extended imm when alu_src=1.
REQ-021 SHALL decode alu_ctr as follows, with overflow 0 for every code not listed as signed:
- 000 ADDU, 001 SUBU: no overflow.
- 010 ADD, 011 SUB: signed, with two's-complement overflow.
- 100 AND, 101 OR.
- 110 SLT signed; 111 SLTU unsigned; both give a result of 0 or 1.
REQ-022 SHALL, for an ALU operation, register result, zero and overflow on the accepting edge and assert out_valid for exactly the following cycle (latency 1).
REQ-023 SHALL run a multiply as an IDLE to MUL to IDLE state machine using shift-add, one multiplier bit per cycle.
REQ-024 SHALL, for a multiply accepted at edge k, iterate on edges k+1 to k+WIDTH, hold busy high from after edge k until after edge k+WIDTH, and assert out_valid for the cycle after edge k+WIDTH.
REQ-025 SHALL give a multiply result equal to the low WIDTH bits of the unsigned product, with overflow 0.
REQ-026 SHALL hold result, zero and overflow stable between out_valid pulses.
REQ-027 SHALL ignore in_valid while busy is high.
REQ-028 SHALL, when flush is high at an edge:
- return the state to IDLE and deassert busy;
- suppress any out_valid that edge would have produced;
- leave result, zero and overflow unchanged;
- drop any operation presented that cycle, because flush wins over acceptance.
REQ-029 SHALL produce no out_valid pulse after a flushed multiply.
REQ-030 SHALL accept a new operation on the edge that completes a multiply only if in_ready was high, which it is not; the first acceptance after a multiply therefore occurs at edge k+WIDTH+1 or later.

Reset
REQ-031 SHALL, while rst_n is low and asynchronously, force the state to IDLE and drive busy=0, out_valid=0, result=0, zero=1 and overflow=0.
REQ-032 SHALL, on reset asserted mid-multiply, discard the partial product and never emit its result.
REQ-033 SHALL accept an operation on the first rising edge after rst_n is released.

Verification
REQ-034 SHALL cover ADD signed overflow at WIDTH=32: bus_a=0x7FFFFFFF, bus_b=1, alu_ctr=010 -> result 0x80000000 and overflow=1 one cycle later; ADDU with the same operands -> overflow=0.
REQ-035 SHALL cover immediate extension: imm=0xFFFF, alu_src=1, bus_a=1, alu_ctr=000; ext_op=1 -> result 0 with zero=1; ext_op=0 -> result 0x00010000.
REQ-036 SHALL cover multiply: bus_a=1234, bus_b=5678, mul_op=1 -> busy for 32 cycles, then out_valid with result 7006652; in_valid during busy is ignored.
REQ-037 SHALL cover flush: flush asserted at iteration 10 of a multiply -> busy=0 next cycle, no out_valid, result unchanged, in_ready=1.
REQ-038 SHALL cover reset mid-operation: rst_n low during a multiply -> immediate busy=0, result=0, zero=1; after release an SLTU with bus_a=1, bus_b=2 -> result 1.
REQ-039 SHALL cover WIDTH=8: 0xFF times 0xFF -> result 0x01 after 8 busy cycles.
